// File: rtl/text_console_pkg.sv
// Shared constants, state encoding and cell packing for the text console writer.
// Imported by text_console_writer; the cell format is {colour[7:0], char[7:0]}.
package text_console_pkg;

    localparam int COLS  = 40;
    localparam int ROWS  = 25;
    localparam int CELLS = COLS * ROWS;

    localparam logic [7:0] CC_BS  = 8'h08;
    localparam logic [7:0] CC_LF  = 8'h0A;
    localparam logic [7:0] CC_FF  = 8'h0C;
    localparam logic [7:0] CC_CR  = 8'h0D;
    localparam logic [7:0] CC_DEL = 8'h7F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_SCR_RD,
        ST_SCR_CAP,
        ST_SCR_WR,
        ST_CLR
    } state_e;

    function automatic logic [15:0] cell_pack(
        input logic [7:0] col,
        input logic [7:0] ch
    );
        return {col, ch};
    endfunction

endpackage

// File: rtl/text_cell_addr.sv
// Combinational (x,y) to linear text RAM address, y*40 + x as y*32 + y*8 + x.
// Ports: x_i column, y_i row, addr_o 10-bit cell address.
module text_cell_addr (
    input  logic [5:0] x_i,
    input  logic [4:0] y_i,
    output logic [9:0] addr_o
);

    assign addr_o = {y_i, 5'b0}
                  + {2'b0, y_i, 3'b0}
                  + {4'b0, x_i};

endmodule

// File: rtl/text_console_writer.sv
// Character-stream front end: cursor, control codes, wrap, scroll and clear.
// Ports: char/col/valid/ready stream in; ram_* CPU port of text RAM; cursor_x/y, busy.
module text_console_writer #(
    parameter int         COLS           = 40,
    parameter int         ROWS           = 25,
    parameter logic [7:0] BLANK_CHAR     = 8'h20,
    parameter logic [7:0] BLANK_COL      = 8'h00,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  char_in,
    input  logic [7:0]  col_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [9:0]  ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_we,
    input  logic [15:0] ram_rdata,
    output logic [5:0]  cursor_x,
    output logic [4:0]  cursor_y,
    output logic        busy
);

    import text_console_pkg::*;

    localparam logic [5:0]  X_MAX = 6'(COLS - 1);
    localparam logic [4:0]  Y_MAX = 5'(ROWS - 1);
    localparam logic [15:0] BLANK = {BLANK_COL, BLANK_CHAR};

    state_e      state_q, state_d;
    logic [5:0]  cx_q, cx_d;
    logic [4:0]  cy_q, cy_d;
    // px/py: write position, or the scroll/clear cell counter
    logic [5:0]  px_q, px_d;
    logic [4:0]  py_q, py_d;
    logic [7:0]  ch_q, ch_d;
    logic [7:0]  col_q, col_d;
    logic [15:0] data_q, data_d;
    logic        bs_q, bs_d;
    logic        first_q, first_d;
    logic        fin_q, fin_d;
    logic        full_q, full_d;

    logic [9:0]  pos_addr;
    logic [9:0]  up_addr;
    logic        is_print;
    logic        p_last;

    text_cell_addr u_pos (
        .x_i    (px_q),
        .y_i    (py_q),
        .addr_o (pos_addr)
    );

    // Destination row of a scroll copy
    text_cell_addr u_up (
        .x_i    (px_q),
        .y_i    (py_q - 5'd1),
        .addr_o (up_addr)
    );

    assign is_print = (char_in >= 8'h20) && (char_in != CC_DEL);
    assign p_last   = (px_q == X_MAX) && (py_q == Y_MAX);
    assign cursor_x = cx_q;
    assign cursor_y = cy_q;

    always_comb begin
        state_d    = state_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        px_d       = px_q;
        py_d       = py_q;
        ch_d       = ch_q;
        col_d      = col_q;
        data_d     = data_q;
        bs_d       = bs_q;
        first_d    = first_q;
        fin_d      = fin_q;
        full_d     = full_q;
        char_ready = 1'b0;
        busy       = 1'b0;
        ram_addr   = 10'd0;
        ram_we     = 1'b0;
        ram_wdata  = 16'd0;

        case (state_q)
            ST_IDLE: begin
                char_ready = 1'b1;
                if (char_valid) begin
                    ch_d  = char_in;
                    col_d = col_in;
                    bs_d  = 1'b0;
                    unique case (1'b1)
                        is_print: begin
                            px_d    = cx_q;
                            py_d    = cy_q;
                            state_d = ST_WR_ADDR;
                        end
                        char_in == CC_LF: begin
                            cx_d = 6'd0;
                            if (cy_q == Y_MAX) begin
                                px_d    = 6'd0;
                                py_d    = 5'd1;
                                state_d = ST_SCR_RD;
                            end else begin
                                cy_d = cy_q + 5'd1;
                            end
                        end
                        char_in == CC_CR: begin
                            cx_d = 6'd0;
                        end
                        char_in == CC_BS: begin
                            if (cx_q != 6'd0) begin
                                px_d    = cx_q - 6'd1;
                                py_d    = cy_q;
                                bs_d    = 1'b1;
                                state_d = ST_WR_ADDR;
                            end else if (cy_q != 5'd0) begin
                                px_d    = X_MAX;
                                py_d    = cy_q - 5'd1;
                                bs_d    = 1'b1;
                                state_d = ST_WR_ADDR;
                            end
                        end
                        char_in == CC_FF: begin
                            px_d    = 6'd0;
                            py_d    = 5'd0;
                            first_d = 1'b1;
                            fin_d   = 1'b0;
                            full_d  = 1'b1;
                            state_d = ST_CLR;
                        end
                        default: ;
                    endcase
                end
            end

            ST_WR_ADDR: begin
                ram_addr = pos_addr;
                state_d  = ST_WR_DATA;
            end

            ST_WR_DATA: begin
                ram_addr  = pos_addr;
                ram_we    = 1'b1;
                ram_wdata = bs_q ? BLANK : cell_pack(col_q, ch_q);
                state_d   = ST_IDLE;
                if (bs_q) begin
                    cx_d = px_q;
                    cy_d = py_q;
                end else if (px_q == X_MAX) begin
                    cx_d = 6'd0;
                    if (py_q == Y_MAX) begin
                        cy_d    = Y_MAX;
                        px_d    = 6'd0;
                        py_d    = 5'd1;
                        state_d = ST_SCR_RD;
                    end else begin
                        cy_d = py_q + 5'd1;
                    end
                end else begin
                    cx_d = px_q + 6'd1;
                    cy_d = py_q;
                end
            end

            ST_SCR_RD: begin
                busy     = 1'b1;
                ram_addr = pos_addr;
                state_d  = ST_SCR_CAP;
            end

            ST_SCR_CAP: begin
                busy     = 1'b1;
                data_d   = ram_rdata;
                ram_addr = up_addr;
                state_d  = ST_SCR_WR;
            end

            // Write cell i-COLS while already fetching cell i+1
            ST_SCR_WR: begin
                busy      = 1'b1;
                ram_we    = 1'b1;
                ram_wdata = data_q;
                ram_addr  = pos_addr + 10'd1;
                if (p_last) begin
                    px_d    = 6'd0;
                    py_d    = Y_MAX;
                    first_d = 1'b1;
                    fin_d   = 1'b0;
                    full_d  = 1'b0;
                    state_d = ST_CLR;
                end else begin
                    if (px_q == X_MAX) begin
                        px_d = 6'd0;
                        py_d = py_q + 5'd1;
                    end else begin
                        px_d = px_q + 6'd1;
                    end
                    state_d = ST_SCR_CAP;
                end
            end

            // Each cycle drives cell k and writes cell k-1
            ST_CLR: begin
                busy = 1'b1;
                if (fin_q) begin
                    ram_we    = 1'b1;
                    ram_wdata = BLANK;
                    state_d   = ST_IDLE;
                    if (full_q) begin
                        cx_d = 6'd0;
                        cy_d = 5'd0;
                    end
                end else begin
                    ram_addr = pos_addr;
                    if (!first_q) begin
                        ram_we    = 1'b1;
                        ram_wdata = BLANK;
                    end
                    first_d = 1'b0;
                    if (p_last) begin
                        fin_d = 1'b1;
                    end else if (px_q == X_MAX) begin
                        px_d = 6'd0;
                        py_d = py_q + 5'd1;
                    end else begin
                        px_d = px_q + 6'd1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLEAR_ON_RESET ? ST_CLR : ST_IDLE;
            cx_q    <= 6'd0;
            cy_q    <= 5'd0;
            px_q    <= 6'd0;
            py_q    <= 5'd0;
            ch_q    <= 8'd0;
            col_q   <= 8'd0;
            data_q  <= 16'd0;
            bs_q    <= 1'b0;
            first_q <= 1'b1;
            fin_q   <= 1'b0;
            full_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            px_q    <= px_d;
            py_q    <= py_d;
            ch_q    <= ch_d;
            col_q   <= col_d;
            data_q  <= data_d;
            bs_q    <= bs_d;
            first_q <= first_d;
            fin_q   <= fin_d;
            full_q  <= full_d;
        end
    end

endmodule
